// File: rtl/scm_pkg.sv
// Shared types and helpers for the latch-based SCM store and its write sequencer.
package scm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int unsigned scm_addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/scm_write_streamer.sv
// Write-side sequencer for the SCM: takes a (base, len) command and a valid/ready beat
// stream, and drives the SCM write port with consecutive, wrapping addresses.
module scm_write_streamer
  import scm_pkg::*;
#(
  parameter int unsigned C             = 32,
  parameter int unsigned K             = 16,
  parameter int unsigned DataTypeWidth = 16,
  parameter int unsigned WaddrLag      = 1,
  localparam int unsigned Depth        = C * K,
  localparam int unsigned AddrWidth    = scm_addr_width(Depth),
  localparam int unsigned LenWidth     = AddrWidth + 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic [AddrWidth-1:0]     cmd_base_i,
  input  logic [LenWidth-1:0]      cmd_len_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [DataTypeWidth-1:0] in_data_i,
  output logic [AddrWidth-1:0]     scm_waddr_o,
  output logic [DataTypeWidth-1:0] scm_wdata_o,
  output logic                     scm_we_o,
  output logic                     busy_o,
  output logic                     done_o
);

  if ((Depth & (Depth - 1)) != 0) begin : g_depth_check
    $error("scm_write_streamer: Depth must be a power of two");
  end

  state_e                   state_q, state_d;
  logic [AddrWidth-1:0]     addr_q, addr_d;
  logic [LenWidth-1:0]      rem_q, rem_d;
  logic [AddrWidth-1:0]     issue_addr_q, issue_addr_d;
  logic [AddrWidth-1:0]     waddr_lag_q, waddr_lag_d;
  logic [DataTypeWidth-1:0] wdata_q, wdata_d;
  logic                     we_q, we_d;
  logic                     cmd_ready_q, cmd_ready_d;
  logic                     in_ready_q, in_ready_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     beat_c;

  // in_ready_q is only ever set while in RUN, so it alone qualifies a beat.
  assign beat_c = in_valid_i & in_ready_q;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, counters and registered-output next values.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    rem_d        = rem_q;
    issue_addr_d = issue_addr_q;
    wdata_d      = wdata_q;
    we_d         = 1'b0;
    waddr_lag_d  = we_q ? issue_addr_q : waddr_lag_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i && cmd_ready_q) begin
          addr_d  = cmd_base_i;
          rem_d   = cmd_len_i;
          state_d = (cmd_len_i == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (beat_c) begin
          we_d         = 1'b1;
          wdata_d      = in_data_i;
          issue_addr_d = addr_q;
          addr_d       = addr_q + AddrWidth'(1);
          rem_d        = rem_q - LenWidth'(1);
        end
        // One drain cycle after the last beat so DONE lines up with the lagged address.
        if (rem_q == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    cmd_ready_d = (state_d == IDLE);
    in_ready_d  = (state_d == RUN) && (rem_d != '0);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
  end

  // Datapath and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q       <= '0;
      rem_q        <= '0;
      issue_addr_q <= '0;
      waddr_lag_q  <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      cmd_ready_q  <= 1'b0;
      in_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      addr_q       <= addr_d;
      rem_q        <= rem_d;
      issue_addr_q <= issue_addr_d;
      waddr_lag_q  <= waddr_lag_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      cmd_ready_q  <= cmd_ready_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  if (WaddrLag != 0) begin : g_waddr_lag
    assign scm_waddr_o = waddr_lag_q;
  end else begin : g_waddr_now
    assign scm_waddr_o = issue_addr_q;
  end

  assign scm_wdata_o = wdata_q;
  assign scm_we_o    = we_q;
  assign cmd_ready_o = cmd_ready_q;
  assign in_ready_o  = in_ready_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_scm_write_streamer.sv
// Directed bench for scm_write_streamer with a write scoreboard and an SCM array model.
module tb_scm_write_streamer;

  localparam int unsigned Depth = 512;
  localparam int unsigned AW    = 9;
  localparam int unsigned DW    = 16;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          cmd_valid_i = 1'b0;
  logic          cmd_ready_o;
  logic [AW-1:0] cmd_base_i = '0;
  logic [AW:0]   cmd_len_i = '0;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic [DW-1:0] in_data_i = '0;
  logic [AW-1:0] scm_waddr_o;
  logic [DW-1:0] scm_wdata_o;
  logic          scm_we_o;
  logic          busy_o;
  logic          done_o;

  scm_write_streamer #(.C(32), .K(16), .DataTypeWidth(DW), .WaddrLag(1)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .cmd_valid_i(cmd_valid_i),
    .cmd_ready_o(cmd_ready_o),
    .cmd_base_i (cmd_base_i),
    .cmd_len_i  (cmd_len_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .in_data_i  (in_data_i),
    .scm_waddr_o(scm_waddr_o),
    .scm_wdata_o(scm_wdata_o),
    .scm_we_o   (scm_we_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  always #5 clk_i = ~clk_i;

  int            vec_cnt = 0;
  int            err_cnt = 0;
  wr_t           sb[$];
  logic [DW-1:0] scm_mem [Depth];
  logic [DW-1:0] ref_mem [Depth];
  logic [AW-1:0] exp_addr = '0;
  logic          lag_pend = 1'b0;
  logic [AW-1:0] pend_addr = '0;
  logic [DW-1:0] pend_data = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, then check the write port against the scoreboard and update the SCM model.
  task automatic tick();
    logic was_rst;
    wr_t  e;
    was_rst = rst_i;
    @(posedge clk_i);
    #1;
    if (was_rst) begin
      lag_pend = 1'b0;
    end else if (lag_pend) begin
      chk("waddr_lagged", 32'(scm_waddr_o), 32'(pend_addr));
      scm_mem[scm_waddr_o] = pend_data;
    end
    lag_pend = 1'b0;
    if (scm_we_o) begin
      if (sb.size() == 0) begin
        chk("we_unexpected", 32'(scm_we_o), 32'(0));
      end else begin
        e = sb.pop_front();
        chk("wdata", 32'(scm_wdata_o), 32'(e.data));
        pend_addr = e.addr;
        pend_data = scm_wdata_o;
        lag_pend  = 1'b1;
      end
    end
  endtask

  task automatic issue_cmd(input logic [AW-1:0] b, input logic [AW:0] l);
    int n;
    n = 0;
    cmd_valid_i = 1'b1;
    cmd_base_i  = b;
    cmd_len_i   = l;
    while (!cmd_ready_o && n < 50) begin
      tick();
      n++;
    end
    chk("cmd_accept", 32'(cmd_ready_o), 32'(1));
    exp_addr = b;
    tick();
    cmd_valid_i = 1'b0;
  endtask

  task automatic drive_beat(input logic v, input logic [DW-1:0] d, output logic acc);
    in_valid_i = v;
    in_data_i  = d;
    acc = v && in_ready_o;
    if (acc) begin
      sb.push_back('{addr: exp_addr, data: d});
      ref_mem[exp_addr] = d;
      exp_addr = exp_addr + AW'(1);
    end
    tick();
    in_valid_i = 1'b0;
    chk("we_follows_beat", 32'(scm_we_o), 32'(acc));
    chk("busy_in_run", 32'(busy_o), 32'(1));
    chk("cmd_ready_in_run", 32'(cmd_ready_o), 32'(0));
  endtask

  // gap: 0 back-to-back, 1 valid toggling 1/0, 2 random gaps.
  task automatic stream(input int n, input int gap);
    int   sent;
    int   cyc;
    logic v;
    logic acc;
    sent = 0;
    cyc  = 0;
    while (sent < n && cyc < 4 * n + 20) begin
      if (gap == 0)      v = 1'b1;
      else if (gap == 1) v = (cyc % 2 == 0);
      else               v = ($urandom_range(0, 3) != 0);
      drive_beat(v, DW'($urandom), acc);
      if (acc) sent++;
      cyc++;
    end
    chk("stream_sent", 32'(sent), 32'(n));
  endtask

  task automatic wait_done(input int exp_lat);
    int lat;
    lat = 0;
    while (!done_o && lat < 20) begin
      tick();
      lat++;
    end
    chk("done_seen", 32'(done_o), 32'(1));
    chk("done_latency", 32'(lat), 32'(exp_lat));
    chk("in_ready_done", 32'(in_ready_o), 32'(0));
    chk("cmd_ready_done", 32'(cmd_ready_o), 32'(0));
    chk("busy_done", 32'(busy_o), 32'(1));
    chk("sb_drained", 32'(sb.size()), 32'(0));
    tick();
    chk("done_one_cycle", 32'(done_o), 32'(0));
    chk("idle_busy", 32'(busy_o), 32'(0));
    chk("idle_cmd_ready", 32'(cmd_ready_o), 32'(1));
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, 32'({cmd_ready_o, in_ready_o, scm_we_o, busy_o, done_o}), 32'(0));
    chk(tag, 32'(scm_waddr_o), 32'(0));
    chk(tag, 32'(scm_wdata_o), 32'(0));
  endtask

  initial begin
    logic acc;

    // Reset state.
    tick();
    tick();
    chk_all_zero("reset_outputs");
    rst_i = 1'b0;
    tick();
    chk("cmd_ready_after_reset", 32'(cmd_ready_o), 32'(1));
    chk("in_ready_idle", 32'(in_ready_o), 32'(0));

    // Beats presented in IDLE are not consumed.
    in_valid_i = 1'b1;
    tick();
    chk("idle_no_we", 32'(scm_we_o), 32'(0));
    chk("idle_no_ready", 32'(in_ready_o), 32'(0));
    in_valid_i = 1'b0;

    // base=5, len=4, back-to-back beats.
    issue_cmd(AW'(5), 10'd4);
    chk("run_in_ready", 32'(in_ready_o), 32'(1));
    drive_beat(1'b1, 16'h000A, acc);
    drive_beat(1'b1, 16'h000B, acc);
    drive_beat(1'b1, 16'h000C, acc);
    drive_beat(1'b1, 16'h000D, acc);
    chk("drain_in_ready", 32'(in_ready_o), 32'(0));
    wait_done(1);
    chk("last_addr_held", 32'(scm_waddr_o), 32'(8));

    // Wrap with valid toggling.
    issue_cmd(AW'(Depth - 2), 10'd3);
    stream(3, 1);
    wait_done(1);

    // len=0: no writes, done right after accept.
    issue_cmd(AW'(7), 10'd0);
    chk("len0_no_we", 32'(scm_we_o), 32'(0));
    wait_done(0);

    // Second command held off during RUN/DONE.
    issue_cmd(AW'(100), 10'd2);
    cmd_valid_i = 1'b1;
    cmd_base_i  = AW'(200);
    cmd_len_i   = 10'd1;
    stream(2, 0);
    wait_done(1);
    exp_addr = AW'(200);
    tick();
    cmd_valid_i = 1'b0;
    chk("cmd2_running", 32'(in_ready_o), 32'(1));
    stream(1, 0);
    wait_done(1);

    // Reset mid-command: outputs clear, no done pulse.
    issue_cmd(AW'(300), 10'd10);
    stream(3, 0);
    rst_i = 1'b1;
    in_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      in_valid_i = 1'b1;
      chk_all_zero("reset_mid_run");
    end
    rst_i = 1'b0;
    in_valid_i = 1'b0;
    tick();
    chk("cmd_ready_after_midreset", 32'(cmd_ready_o), 32'(1));
    chk("no_done_after_midreset", 32'(done_o), 32'(0));
    chk("busy_after_midreset", 32'(busy_o), 32'(0));

    // Full-depth random load, then read back the SCM model.
    issue_cmd(AW'(37), 10'(Depth));
    stream(Depth, 2);
    wait_done(1);
    for (int a = 0; a < Depth; a++) begin
      chk("readback", 32'(scm_mem[a]), 32'(ref_mem[a]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
